vend_arbiter: RTL and testbench

Front-end controller that shares one vending datapath (credit accumulator, product dispenser, nickel change ejector) between two customer panels. It grants the machine to one panel at a time and accumulates that panel's coins. It sequences a dispense handshake and a nickel-by-nickel change/refund handshake, then releases the machine round-robin. It sits between the panel coin/selection inputs and the dispenser/ejector mechanisms.

---
 rtl/vend_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_vend_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// vend_arbiter: shares one vending datapath between two customer panels.
// Grants the machine to one panel at a time, accumulates that panel's coins,
// sequences the dispense handshake and nickel-by-nickel change/refund, then
// releases the machine round-robin.
//
// Ports:
//   clk, rst          - clock (rising edge) and synchronous active-high reset
//   coin_q/d/n [1:0]  - quarter/dime/nickel pulses, bit p = panel p
//   sel_soda/diet[1:0]- product selections per panel
//   disp_busy         - dispenser busy while a product drops
//   chg_busy          - ejector busy while a nickel is ejected
//   grant [1:0]       - one-hot owning panel, 0 when idle
//   reject [1:0]      - one-cycle coin-return pulse per panel
//   credit [6:0]      - current owner credit in cents
//   vend_soda/diet    - one-cycle dispense commands
//   change_nickel     - one-cycle eject-one-nickel command
module vend_arbiter #(
  parameter int unsigned PRICE      = 45,
  parameter int unsigned MAX_CREDIT = 65,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_q,
  input  logic [1:0] coin_d,
  input  logic [1:0] coin_n,
  input  logic [1:0] sel_soda,
  input  logic [1:0] sel_diet,
  input  logic       disp_busy,
  input  logic       chg_busy,
  output logic [1:0] grant,
  output logic [1:0] reject,
  output logic [6:0] credit,
  output logic       vend_soda,
  output logic       vend_diet,
  output logic       change_nickel
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_C   = 8'(MAX_CREDIT);
  localparam logic [6:0]    PRICE_C = 7'(PRICE);
  localparam logic [TW-1:0] TIME_C  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [6:0]    credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          diet_q, diet_d;
  logic          pulsed_q, pulsed_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    reject_q, reject_d;
  logic          vend_soda_q, vend_soda_d;
  logic          vend_diet_q, vend_diet_d;
  logic          change_nickel_q, change_nickel_d;

  function automatic logic [4:0] coin_value(input logic q, input logic d, input logic n);
    if (q)      return 5'd25;
    else if (d) return 5'd10;
    else if (n) return 5'd5;
    else        return 5'd0;
  endfunction

  logic [4:0]    val0, val1, own_val, win_val;
  logic [1:0]    coin_any, coin_multi;
  logic          own_any, oth_any, own_multi, own_soda, own_diet;
  logic          win, accepted, rej_own, rej_oth, release_now;
  logic [7:0]    sum;
  logic [TW-1:0] timer_inc;

  always_comb begin
    val0          = coin_value(coin_q[0], coin_d[0], coin_n[0]);
    val1          = coin_value(coin_q[1], coin_d[1], coin_n[1]);
    coin_any      = coin_q | coin_d | coin_n;
    coin_multi    = (coin_q & coin_d) | (coin_q & coin_n) | (coin_d & coin_n);
    own_any       = owner_q ? coin_any[1]   : coin_any[0];
    oth_any       = owner_q ? coin_any[0]   : coin_any[1];
    own_val       = owner_q ? val1          : val0;
    own_multi     = owner_q ? coin_multi[1] : coin_multi[0];
    own_soda      = owner_q ? sel_soda[1]   : sel_soda[0];
    own_diet      = owner_q ? sel_diet[1]   : sel_diet[0];
    sum           = {1'b0, credit_q} + {3'b000, own_val};
    timer_inc     = timer_q + 1'b1;
    // Simultaneous coins go to the favoured panel; a lone coin owns outright.
    win           = (&coin_any) ? rr_q : coin_any[1];
    win_val       = win ? val1 : val0;
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    credit_d        = credit_q;
    timer_d         = timer_q;
    diet_d          = diet_q;
    pulsed_d        = pulsed_q;
    grant_d         = grant_q;
    reject_d        = '0;
    vend_soda_d     = 1'b0;
    vend_diet_d     = 1'b0;
    change_nickel_d = 1'b0;
    accepted        = 1'b0;
    rej_own         = 1'b0;
    rej_oth         = 1'b0;
    release_now     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|coin_any) begin
          owner_d  = win;
          grant_d  = win ? 2'b10 : 2'b01;
          credit_d = {2'b00, win_val};
          timer_d  = '0;
          state_d  = COLLECT;
          if (win) reject_d = {coin_multi[1], coin_any[0]};
          else     reject_d = {coin_any[1], coin_multi[0]};
        end
      end

      COLLECT: begin
        rej_oth = oth_any;
        if (own_any) begin
          if (sum <= MAX_C) begin
            credit_d = sum[6:0];
            accepted = 1'b1;
            rej_own  = own_multi;
          end else begin
            rej_own  = 1'b1;
          end
        end
        timer_d = accepted ? '0 : timer_inc;
        // Any owner coin this cycle, even a rejected one, masks the selection.
        if (!own_any && (own_soda || own_diet) && credit_q >= PRICE_C) begin
          state_d  = VEND;
          diet_d   = !own_soda;
          pulsed_d = 1'b0;
        end else if (!accepted && timer_inc == TIME_C) begin
          state_d  = CHANGE;
        end
        reject_d = owner_q ? {rej_own, rej_oth} : {rej_oth, rej_own};
      end

      VEND: begin
        reject_d = coin_any;
        if (!pulsed_q) begin
          if (!disp_busy) begin
            vend_soda_d = !diet_q;
            vend_diet_d = diet_q;
            credit_d    = credit_q - PRICE_C;
            pulsed_d    = 1'b1;
          end
        end else if (vend_soda_q || vend_diet_q) begin
          // Dispenser may not have raised busy yet; skip one cycle.
        end else if (!disp_busy) begin
          if (credit_q != '0) state_d = CHANGE;
          else                release_now = 1'b1;
        end
      end

      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          release_now = 1'b1;
        end else if (!chg_busy && !change_nickel_q) begin
          change_nickel_d = 1'b1;
          credit_d        = credit_q - 7'd5;
          if (credit_q == 7'd5) release_now = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (release_now) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = !owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      rr_q            <= 1'b0;
      credit_q        <= '0;
      timer_q         <= '0;
      diet_q          <= 1'b0;
      pulsed_q        <= 1'b0;
      grant_q         <= '0;
      reject_q        <= '0;
      vend_soda_q     <= 1'b0;
      vend_diet_q     <= 1'b0;
      change_nickel_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      diet_q          <= diet_d;
      pulsed_q        <= pulsed_d;
      grant_q         <= grant_d;
      reject_q        <= reject_d;
      vend_soda_q     <= vend_soda_d;
      vend_diet_q     <= vend_diet_d;
      change_nickel_q <= change_nickel_d;
    end
  end

  assign grant         = grant_q;
  assign reject        = reject_q;
  assign credit        = credit_q;
  assign vend_soda     = vend_soda_q;
  assign vend_diet     = vend_diet_q;
  assign change_nickel = change_nickel_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Bench for vend_arbiter: directed scenarios with fixed expectations, then
// random traffic, all compared every cycle against a session-level model.
module tb_vend_arbiter;

  localparam int PRICE = 45;
  localparam int MAXC  = 65;
  localparam int TO    = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_q, coin_d, coin_n, sel_soda, sel_diet;
  logic       disp_busy, chg_busy;
  logic [1:0] grant, reject;
  logic [6:0] credit;
  logic       vend_soda, vend_diet, change_nickel;

  vend_arbiter #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
    .sel_soda(sel_soda), .sel_diet(sel_diet),
    .disp_busy(disp_busy), .chg_busy(chg_busy),
    .grant(grant), .reject(reject), .credit(credit),
    .vend_soda(vend_soda), .vend_diet(vend_diet), .change_nickel(change_nickel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_vs, n_vd, n_cn, last_cn_cyc, min_gap, credit_at_vend;

  // Session-level reference model
  bit         m_active, m_refund, m_diet;
  int         m_owner, m_rr, m_credit, m_idle, m_stage;
  logic [1:0] e_grant = 2'b00, e_rej = 2'b00;
  logic       e_vs = 1'b0, e_vd = 1'b0, e_cn = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int cents(input logic q, input logic d, input logic n);
    if (q) return 25;
    if (d) return 10;
    if (n) return 5;
    return 0;
  endfunction

  function automatic logic rb(input int den);
    return ($urandom_range(den - 1) == 0);
  endfunction

  task automatic model_step();
    int v[2];
    int nl[2];
    int o, x, w;
    bit acc, prev_cn, rel;
    for (int p = 0; p < 2; p++) begin
      v[p]  = cents(coin_q[p], coin_d[p], coin_n[p]);
      nl[p] = int'(coin_q[p]) + int'(coin_d[p]) + int'(coin_n[p]);
    end
    prev_cn = e_cn;
    e_rej = 2'b00; e_vs = 1'b0; e_vd = 1'b0; e_cn = 1'b0;
    rel = 0;
    if (rst) begin
      m_active = 0; m_rr = 0; m_credit = 0; m_idle = 0;
      m_stage = 0; m_refund = 0; m_owner = 0;
    end else if (!m_active) begin
      if (v[0] != 0 || v[1] != 0) begin
        w = (v[0] != 0 && v[1] != 0) ? m_rr : (v[0] != 0 ? 0 : 1);
        m_active = 1; m_owner = w; m_credit = v[w]; m_idle = 0;
        m_stage = 0; m_refund = 0;
        if (v[1 - w] != 0) e_rej[1 - w] = 1'b1;
        if (nl[w] > 1) e_rej[w] = 1'b1;
      end
    end else if (m_refund) begin
      e_rej = {v[1] != 0, v[0] != 0};
      if (m_credit == 0) rel = 1;
      else if (!chg_busy && !prev_cn) begin
        e_cn = 1'b1;
        m_credit -= 5;
        if (m_credit == 0) rel = 1;
      end
    end else if (m_stage != 0) begin
      e_rej = {v[1] != 0, v[0] != 0};
      if (m_stage == 1) begin
        if (!disp_busy) begin
          e_vs = !m_diet; e_vd = m_diet;
          m_credit -= PRICE;
          m_stage = 2;
        end
      end else if (m_stage == 2) begin
        m_stage = 3;
      end else if (!disp_busy) begin
        m_stage = 0;
        if (m_credit > 0) m_refund = 1;
        else rel = 1;
      end
    end else begin
      o = m_owner; x = 1 - o; acc = 0;
      if (v[x] != 0) e_rej[x] = 1'b1;
      if (v[o] != 0) begin
        if (m_credit + v[o] <= MAXC) begin
          m_credit += v[o]; acc = 1;
          if (nl[o] > 1) e_rej[o] = 1'b1;
        end else e_rej[o] = 1'b1;
      end
      if (acc) m_idle = 0; else m_idle++;
      if (v[o] == 0 && (sel_soda[o] || sel_diet[o]) && m_credit >= PRICE) begin
        m_stage = 1; m_diet = !sel_soda[o];
      end else if (!acc && m_idle == TO) m_refund = 1;
    end
    if (rel) begin
      m_active = 0; m_rr = 1 - m_owner; m_stage = 0; m_refund = 0;
    end
    e_grant = !m_active ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("grant", int'(grant), int'(e_grant));
    chk("reject", int'(reject), int'(e_rej));
    chk("credit", int'(credit), m_credit);
    chk("vend_soda", int'(vend_soda), int'(e_vs));
    chk("vend_diet", int'(vend_diet), int'(e_vd));
    chk("change_nickel", int'(change_nickel), int'(e_cn));
    if (vend_soda || vend_diet) credit_at_vend = int'(credit);
    n_vs += int'(vend_soda);
    n_vd += int'(vend_diet);
    if (change_nickel) begin
      n_cn++;
      if (last_cn_cyc >= 0 && cyc - last_cn_cyc < min_gap) min_gap = cyc - last_cn_cyc;
      last_cn_cyc = cyc;
    end
  endtask

  task automatic clear_in();
    coin_q = '0; coin_d = '0; coin_n = '0; sel_soda = '0; sel_diet = '0;
  endtask

  task automatic clear_counts();
    n_vs = 0; n_vd = 0; n_cn = 0; last_cn_cyc = -1; min_gap = 1000; credit_at_vend = -1;
  endtask

  task automatic coin1(input logic [1:0] q, input logic [1:0] d, input logic [1:0] n);
    coin_q = q; coin_d = d; coin_n = n;
    tick();
    clear_in();
  endtask

  task automatic wait_release(input string tag, input int limit);
    for (int i = 0; i < limit && grant != 2'b00; i++) tick();
    chk(tag, int'(grant), 0);
  endtask

  initial begin
    rst = 1'b1; disp_busy = 1'b0; chg_busy = 1'b0;
    clear_in(); clear_counts();
    tick(); tick();
    chk("reset_grant", int'(grant), 0);
    chk("reset_credit", int'(credit), 0);
    rst = 1'b0;

    // Panel 0: 25 + 10 + 10, soda
    coin1(2'b01, 2'b00, 2'b00); chk("t1_credit25", int'(credit), 25);
    chk("t1_grant", int'(grant), 1);
    coin1(2'b00, 2'b01, 2'b00); chk("t1_credit35", int'(credit), 35);
    coin1(2'b00, 2'b01, 2'b00); chk("t1_credit45", int'(credit), 45);
    sel_soda = 2'b01; tick(); clear_in();
    wait_release("t1_release", 20);
    chk("t1_vends", n_vs, 1);
    chk("t1_credit0", int'(credit), 0);

    // rr now favours panel 1; then panel 1 builds 55 and buys diet
    clear_counts();
    coin1(2'b11, 2'b00, 2'b00);
    chk("t2_grant_rr1", int'(grant), 2);
    chk("t2_reject", int'(reject), 1);
    coin1(2'b10, 2'b00, 2'b00);
    coin1(2'b00, 2'b00, 2'b10); chk("t2_credit55", int'(credit), 55);
    sel_diet = 2'b10; tick(); clear_in();
    wait_release("t2_release", 30);
    chk("t2_vend_diet", n_vd, 1);
    chk("t2_credit_after_vend", credit_at_vend, 10);
    chk("t2_nickels", n_cn, 2);
    chk("t2_nickel_gap", int'(min_gap >= 2), 1);

    // Simultaneous quarters from reset, then after release
    rst = 1'b1; tick(); rst = 1'b0;
    coin1(2'b11, 2'b00, 2'b00);
    chk("t3_grant", int'(grant), 1);
    chk("t3_reject", int'(reject), 2);
    coin1(2'b00, 2'b01, 2'b00);
    coin1(2'b00, 2'b01, 2'b00);
    sel_soda = 2'b01; tick(); clear_in();
    wait_release("t3_release", 20);
    coin1(2'b11, 2'b00, 2'b00);
    chk("t3_grant2", int'(grant), 2);

    // Overflow and non-owner coins
    coin1(2'b10, 2'b00, 2'b00);
    coin1(2'b00, 2'b10, 2'b00); chk("t4_credit60", int'(credit), 60);
    coin1(2'b10, 2'b00, 2'b00);
    chk("t4_over_reject", int'(reject), 2);
    chk("t4_over_credit", int'(credit), 60);
    coin1(2'b00, 2'b01, 2'b00);
    chk("t4_other_reject", int'(reject), 1);
    chk("t4_other_credit", int'(credit), 60);
    clear_counts();
    sel_diet = 2'b10; tick(); clear_in();
    wait_release("t4_release", 30);
    chk("t4_nickels", n_cn, 3);

    // Timeout refund of 15 cents
    clear_counts();
    coin1(2'b00, 2'b01, 2'b00);
    coin1(2'b00, 2'b00, 2'b01); chk("t5_credit15", int'(credit), 15);
    wait_release("t5_release", TO + 30);
    chk("t5_nickels", n_cn, 3);

    // Selection below price is ignored
    clear_counts();
    coin1(2'b10, 2'b00, 2'b00);
    coin1(2'b00, 2'b10, 2'b00);
    coin1(2'b00, 2'b00, 2'b10);
    sel_diet = 2'b10; tick(); clear_in();
    tick(); tick(); tick();
    chk("t5_no_vend", n_vs + n_vd, 0);
    chk("t5_credit40", int'(credit), 40);
    chk("t5_grant40", int'(grant), 2);
    wait_release("t5_release40", TO + 40);
    chk("t5_refund40", n_cn, 8);

    // Dispenser busy stalls the vend; reset mid-change
    clear_counts();
    coin1(2'b01, 2'b00, 2'b00);
    coin1(2'b01, 2'b00, 2'b00);
    coin1(2'b00, 2'b01, 2'b00);
    disp_busy = 1'b1; sel_soda = 2'b01; tick(); clear_in();
    for (int i = 0; i < 10; i++) tick();
    chk("t6_stalled", n_vs, 0);
    disp_busy = 1'b0; tick();
    chk("t6_vend_pulse", int'(vend_soda), 1);
    chk("t6_credit15", int'(credit), 15);
    for (int i = 0; i < 10 && n_cn == 0; i++) tick();
    chk("t6_first_nickel", n_cn, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_grant", int'(grant), 0);
    chk("t6_rst_credit", int'(credit), 0);
    chk("t6_rst_pulses", int'({reject, vend_soda, vend_diet, change_nickel}), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_change_dropped", n_cn, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int lvl, den;
      lvl = (i / 150) % 3;
      den = (lvl == 0) ? 1000 : ((lvl == 1) ? 14 : 5);
      coin_q    = {rb(den), rb(den)};
      coin_d    = {rb(den), rb(den)};
      coin_n    = {rb(den), rb(den)};
      sel_soda  = {rb(6), rb(6)};
      sel_diet  = {rb(6), rb(6)};
      disp_busy = rb(2);
      chg_busy  = rb(3);
      rst       = rb(600);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
